// File: rtl/median_mem_arbiter_if.sv
// median_mem_arbiter_if: requester, memory and status signals shared by the
// filtered-image memory arbiter and its surroundings.
interface median_mem_arbiter_if #(parameter int ADDR_W = 8);
    logic              wr_req;
    logic [ADDR_W-1:0] wr_x;
    logic [ADDR_W-1:0] wr_y;
    logic              wr_data;
    logic              wr_gnt;
    logic              hist_req;
    logic [ADDR_W-1:0] hist_x;
    logic [ADDR_W-1:0] hist_y;
    logic              hist_gnt;
    logic              hist_rvalid;
    logic              user_req;
    logic [ADDR_W-1:0] user_x;
    logic [ADDR_W-1:0] user_y;
    logic              user_gnt;
    logic              user_rvalid;
    logic              rd_data;
    logic [ADDR_W-1:0] mem_x;
    logic [ADDR_W-1:0] mem_y;
    logic              mem_wdata;
    logic              mem_write;
    logic              mem_rdata;
    logic              busy;

    modport slave (
        input  wr_req, wr_x, wr_y, wr_data, hist_req, hist_x, hist_y,
               user_req, user_x, user_y, mem_rdata,
        output wr_gnt, hist_gnt, hist_rvalid, user_gnt, user_rvalid, rd_data,
               mem_x, mem_y, mem_wdata, mem_write, busy
    );

    modport master (
        output wr_req, wr_x, wr_y, wr_data, hist_req, hist_x, hist_y,
               user_req, user_x, user_y, mem_rdata,
        input  wr_gnt, hist_gnt, hist_rvalid, user_gnt, user_rvalid, rd_data,
               mem_x, mem_y, mem_wdata, mem_write, busy
    );
endinterface

// File: rtl/median_mem_arbiter.sv
// median_mem_arbiter: one registered access per cycle to the filtered-image memory,
// writer first, round-robin readers with a starvation override, tagged read return.
module median_mem_arbiter #(
    parameter int ADDR_W       = 8,
    parameter int RD_LAT       = 1,
    parameter int STARVE_LIMIT = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    median_mem_arbiter_if.slave  bus
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {NONE, WR, HIST, USER} win_t;

    win_t              win;
    logic              rr;
    logic [CW-1:0]     hist_cnt;
    logic [CW-1:0]     user_cnt;
    logic [RD_LAT-1:0] hist_tag;
    logic [RD_LAT-1:0] user_tag;
    logic              hist_starve;
    logic              user_starve;

    assign hist_starve = bus.hist_req && hist_cnt == LIM;
    assign user_starve = bus.user_req && user_cnt == LIM;

    // rr low favours the histogram reader, high favours the user path
    assign win = (hist_starve && user_starve) ? (rr ? USER : HIST) :
                 hist_starve ? HIST :
                 user_starve ? USER :
                 bus.wr_req ? WR :
                 (bus.hist_req && (!rr || !bus.user_req)) ? HIST :
                 bus.user_req ? USER : NONE;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.wr_gnt    <= 1'b0;
            bus.hist_gnt  <= 1'b0;
            bus.user_gnt  <= 1'b0;
            bus.mem_write <= 1'b0;
            bus.mem_x     <= '0;
            bus.mem_y     <= '0;
            bus.mem_wdata <= 1'b0;
            rr            <= 1'b0;
            hist_cnt      <= '0;
            user_cnt      <= '0;
            hist_tag      <= '0;
            user_tag      <= '0;
        end else begin
            bus.wr_gnt    <= win == WR;
            bus.hist_gnt  <= win == HIST;
            bus.user_gnt  <= win == USER;
            bus.mem_write <= win == WR;
            if (win != NONE) begin
                bus.mem_x <= win == WR ? bus.wr_x : win == HIST ? bus.hist_x : bus.user_x;
                bus.mem_y <= win == WR ? bus.wr_y : win == HIST ? bus.hist_y : bus.user_y;
            end
            if (win == WR)
                bus.mem_wdata <= bus.wr_data;
            if (win == HIST || win == USER)
                rr <= win == HIST;
            hist_cnt <= (!bus.hist_req || win == HIST) ? '0 : hist_cnt == LIM ? hist_cnt : hist_cnt + 1'b1;
            user_cnt <= (!bus.user_req || win == USER) ? '0 : user_cnt == LIM ? user_cnt : user_cnt + 1'b1;
            // the registered grant is the issue stage, so the tag emerges RD_LAT cycles after it
            hist_tag <= (hist_tag << 1) | RD_LAT'(bus.hist_gnt);
            user_tag <= (user_tag << 1) | RD_LAT'(bus.user_gnt);
        end
    end

    assign bus.rd_data     = bus.mem_rdata;
    assign bus.hist_rvalid = hist_tag[RD_LAT-1];
    assign bus.user_rvalid = user_tag[RD_LAT-1];
    assign bus.busy        = bus.wr_gnt || bus.hist_gnt || bus.user_gnt || |hist_tag || |user_tag;
endmodule

// File: tb/tb_median_mem_arbiter.sv
// tb_median_mem_arbiter: directed steps with a read-return scoreboard for median_mem_arbiter.
module tb_median_mem_arbiter;
    localparam int AW = 8;
    localparam int RD_LAT = 2;
    localparam int SL = 15;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int checks = 0;
    int errors = 0;
    logic [1:0] q[$];
    logic [1:0] mon_e;
    bit wmask [65536];
    bit wval [65536];
    logic [RD_LAT-1:0] rpipe;

    median_mem_arbiter_if #(.ADDR_W(AW)) bus();

    median_mem_arbiter #(.ADDR_W(AW), .RD_LAT(RD_LAT), .STARVE_LIMIT(SL)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic pat(input logic [7:0] x, input logic [7:0] y);
        return ~^{x, y};
    endfunction

    // memory model: background pattern overlaid by written cells, RD_LAT read pipeline
    always @(posedge clk) begin
        rpipe <= (rpipe << 1) | RD_LAT'(wmask[{bus.mem_x, bus.mem_y}] ? wval[{bus.mem_x, bus.mem_y}] : pat(bus.mem_x, bus.mem_y));
        if (bus.mem_write) begin
            wmask[{bus.mem_x, bus.mem_y}] <= 1'b1;
            wval[{bus.mem_x, bus.mem_y}]  <= bus.mem_wdata;
        end
    end
    assign bus.mem_rdata = rpipe[RD_LAT-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // scoreboard entries: {1 = user / 0 = hist, expected data}
    always @(negedge clk) begin
        if (reset && (bus.hist_rvalid || bus.user_rvalid)) begin
            if (q.size() == 0) chk("rvalid_unexpected", {bus.hist_rvalid, bus.user_rvalid}, 2'b00);
            else begin
                mon_e = q.pop_front();
                chk("rtag", {bus.hist_rvalid, bus.user_rvalid}, mon_e[1] ? 2'b01 : 2'b10);
                chk("rdata", bus.rd_data, mon_e[0]);
            end
        end
    end

    initial begin
        bus.wr_req = 0; bus.wr_x = 0; bus.wr_y = 0; bus.wr_data = 0;
        bus.hist_req = 0; bus.hist_x = 0; bus.hist_y = 0;
        bus.user_req = 0; bus.user_x = 0; bus.user_y = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", {bus.wr_gnt, bus.hist_gnt, bus.user_gnt, bus.mem_write, bus.mem_x, bus.mem_y,
                            bus.mem_wdata, bus.busy, bus.hist_rvalid, bus.user_rvalid}, 0);
        @(negedge clk);
        reset = 1'b1;

        // single write
        bus.wr_req = 1; bus.wr_x = 3; bus.wr_y = 5; bus.wr_data = 1;
        step;
        chk("wr_flags", {bus.wr_gnt, bus.hist_gnt, bus.user_gnt, bus.mem_write, bus.mem_wdata, bus.busy}, 6'b100111);
        chk("wr_addr", {bus.mem_x, bus.mem_y}, {8'd3, 8'd5});
        bus.wr_req = 0;
        step;
        chk("wr_done", {bus.wr_gnt, bus.mem_write, bus.busy}, 3'b000);
        chk("addr_hold", {bus.mem_x, bus.mem_y}, {8'd3, 8'd5});

        // single histogram read, latency 2
        bus.hist_req = 1; bus.hist_x = 10; bus.hist_y = 20;
        step;
        chk("hist_gnt", {bus.wr_gnt, bus.hist_gnt, bus.user_gnt, bus.mem_write}, 4'b0100);
        chk("hist_addr", {bus.mem_x, bus.mem_y}, {8'd10, 8'd20});
        q.push_back({1'b0, pat(10, 20)});
        bus.hist_req = 0;
        step;
        chk("hist_lat1", {bus.hist_rvalid, bus.user_rvalid, bus.busy}, 3'b001);
        step;
        chk("hist_lat2", {bus.hist_rvalid, bus.user_rvalid, bus.rd_data}, 3'b101);
        step;
        chk("idle_busy", bus.busy, 1'b0);

        // both readers continuously; pointer now favours user
        bus.hist_req = 1; bus.hist_x = 1; bus.hist_y = 2;
        bus.user_req = 1; bus.user_x = 7; bus.user_y = 9;
        for (int i = 0; i < 8; i++) begin
            step;
            chk("rr_gnt", {bus.wr_gnt, bus.hist_gnt, bus.user_gnt}, (i % 2 == 0) ? 3'b001 : 3'b010);
            q.push_back((i % 2 == 0) ? {1'b1, pat(7, 9)} : {1'b0, pat(1, 2)});
        end
        bus.hist_req = 0; bus.user_req = 0;
        repeat (RD_LAT + 1) step;
        chk("rr_drain_busy", bus.busy, 1'b0);

        // writer held with a histogram reader: starvation override every SL+1 cycles
        bus.wr_req = 1; bus.wr_x = 200; bus.wr_y = 200; bus.wr_data = 0;
        bus.hist_req = 1;
        for (int i = 0; i < 100; i++) begin
            step;
            chk("starve_gnt", {bus.wr_gnt, bus.hist_gnt}, (i % (SL + 1) == SL) ? 2'b01 : 2'b10);
            if (i % (SL + 1) == SL) q.push_back({1'b0, pat(1, 2)});
        end
        bus.wr_req = 0; bus.hist_req = 0;
        repeat (RD_LAT + 1) step;

        // write and both reads together; write wins, pointer still favours user
        bus.wr_req = 1; bus.wr_x = 50; bus.wr_y = 60; bus.wr_data = 1;
        bus.hist_req = 1; bus.hist_x = 10; bus.hist_y = 20;
        bus.user_req = 1; bus.user_x = 7; bus.user_y = 9;
        step;
        chk("mix_wr", {bus.wr_gnt, bus.hist_gnt, bus.user_gnt, bus.mem_write}, 4'b1001);
        bus.wr_req = 0;
        step;
        chk("mix_user", {bus.wr_gnt, bus.hist_gnt, bus.user_gnt, bus.mem_write}, 4'b0010);
        chk("mix_user_addr", {bus.mem_x, bus.mem_y}, {8'd7, 8'd9});
        q.push_back({1'b1, pat(7, 9)});
        bus.user_req = 0;
        step;
        chk("mix_hist", {bus.wr_gnt, bus.hist_gnt, bus.user_gnt}, 3'b010);
        q.push_back({1'b0, pat(10, 20)});
        bus.hist_req = 0;
        repeat (RD_LAT + 1) step;

        // two reads in flight, then reset
        bus.hist_req = 1; bus.hist_x = 1; bus.hist_y = 2;
        bus.user_req = 1; bus.user_x = 7; bus.user_y = 9;
        step;
        chk("pre_rst_user", {bus.hist_gnt, bus.user_gnt}, 2'b01);
        step;
        chk("pre_rst_hist", {bus.hist_gnt, bus.user_gnt}, 2'b10);
        reset = 1'b0;
        #1;
        chk("async_reset", {bus.wr_gnt, bus.hist_gnt, bus.user_gnt, bus.mem_write, bus.mem_x, bus.mem_y,
                            bus.mem_wdata, bus.busy, bus.hist_rvalid, bus.user_rvalid}, 0);
        bus.hist_x = 4; bus.hist_y = 4;
        bus.user_x = 9; bus.user_y = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        step;
        chk("post_rst_hist", {bus.hist_gnt, bus.user_gnt, bus.hist_rvalid, bus.user_rvalid}, 4'b1000);
        q.push_back({1'b0, pat(4, 4)});
        bus.hist_req = 0;
        step;
        chk("post_rst_user", {bus.hist_gnt, bus.user_gnt, bus.hist_rvalid, bus.user_rvalid}, 4'b0100);
        q.push_back({1'b1, pat(9, 1)});
        bus.user_req = 0;
        repeat (RD_LAT + 2) step;
        chk("queue_empty", q.size(), 0);
        chk("final_busy", bus.busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
